// File: rtl/booth_mult_sequencer_pkg.sv
// Shared definitions for the Booth multiplier stream sequencer:
// FSM state codes, default widths/timeouts and the product reported on a timeout.
package booth_mult_sequencer_pkg;

    localparam int L_WORD_DEF    = 4;
    localparam int L_CNT_DEF     = 5;
    localparam int BUSY_WAIT_DEF = 2;
    localparam int DONE_WAIT_DEF = 20;

    // Product value reported whenever the watchdog ends an operation.
    localparam logic [2*L_WORD_DEF-1:0] ERR_PRODUCT = '0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_HOLD      = 3'd4
    } seq_state_e;

endpackage

// File: rtl/booth_seq_watchdog.sv
// Loadable up-counter for the sequencer's timeouts; hit_o flags that the next
// increment would reach the selected limit minus one.
module booth_seq_watchdog
    import booth_mult_sequencer_pkg::*;
#(
    parameter int L_cnt     = L_CNT_DEF,
    parameter int BUSY_WAIT = BUSY_WAIT_DEF,
    parameter int DONE_WAIT = DONE_WAIT_DEF
) (
    input  logic clk,
    input  logic srst,
    input  logic clr_i,
    input  logic inc_i,
    input  logic sel_done_i,
    output logic hit_o
);
    localparam logic [L_cnt-1:0] BUSY_LAST = L_cnt'(BUSY_WAIT - 1);
    localparam logic [L_cnt-1:0] DONE_LAST = L_cnt'(DONE_WAIT - 1);

    logic [L_cnt-1:0] cnt_q;
    logic [L_cnt-1:0] cnt_d;
    logic [L_cnt-1:0] cnt_inc;
    logic [L_cnt-1:0] limit;

    assign cnt_inc = cnt_q + L_cnt'(1);
    assign limit   = sel_done_i ? DONE_LAST : BUSY_LAST;
    // Match on the incremented value so the timeout fires on the cycle the
    // count would arrive at the limit.
    assign hit_o   = (cnt_inc == limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/booth_mult_sequencer.sv
// Valid/ready front end for the Booth multiplier: issues Start, tracks the
// Ready level to completion (with watchdog), and holds the product for output.
module booth_mult_sequencer
    import booth_mult_sequencer_pkg::*;
#(
    parameter int L_word    = L_WORD_DEF,
    parameter int L_cnt     = L_CNT_DEF,
    parameter int BUSY_WAIT = BUSY_WAIT_DEF,
    parameter int DONE_WAIT = DONE_WAIT_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [L_word-1:0]   in_word1,
    input  logic [L_word-1:0]   in_word2,
    output logic [L_word-1:0]   mul_word1,
    output logic [L_word-1:0]   mul_word2,
    output logic                mul_start,
    input  logic                mul_ready,
    input  logic [2*L_word-1:0] mul_product,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*L_word-1:0] out_product,
    output logic                out_err,
    output logic [7:0]          done_count
);
    seq_state_e          state_q;
    seq_state_e          state_d;
    logic [L_word-1:0]   word1_q;
    logic [L_word-1:0]   word1_d;
    logic [L_word-1:0]   word2_q;
    logic [L_word-1:0]   word2_d;
    logic [2*L_word-1:0] product_q;
    logic [2*L_word-1:0] product_d;
    logic                err_q;
    logic                err_d;
    logic [7:0]          done_q;
    logic [7:0]          done_d;

    logic accept_en;
    logic start_en;
    logic wd_clr;
    logic wd_inc;
    logic wd_sel_done;
    logic wd_hit;

    booth_seq_watchdog #(
        .L_cnt     (L_cnt),
        .BUSY_WAIT (BUSY_WAIT),
        .DONE_WAIT (DONE_WAIT)
    ) u_watchdog (
        .clk        (clock),
        .srst       (reset),
        .clr_i      (wd_clr),
        .inc_i      (wd_inc),
        .sel_done_i (wd_sel_done),
        .hit_o      (wd_hit)
    );

    always_comb begin
        state_d     = state_q;
        word1_d     = word1_q;
        word2_d     = word2_q;
        product_d   = product_q;
        err_d       = err_q;
        done_d      = done_q;
        accept_en   = 1'b0;
        start_en    = 1'b0;
        wd_clr      = 1'b0;
        wd_inc      = 1'b0;
        wd_sel_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                accept_en = 1'b1;
                if (in_valid) begin
                    word1_d = in_word1;
                    word2_d = in_word2;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                wd_clr = 1'b1;
                // A multiplier still busy from before reset is never restarted.
                if (mul_ready) begin
                    start_en = 1'b1;
                    state_d  = S_WAIT_BUSY;
                end
            end

            S_WAIT_BUSY: begin
                if (!mul_ready) begin
                    wd_clr  = 1'b1;
                    state_d = S_WAIT_DONE;
                end else if (wd_hit) begin
                    product_d = (2*L_word)'(ERR_PRODUCT);
                    err_d     = 1'b1;
                    state_d   = S_HOLD;
                end else begin
                    wd_inc = 1'b1;
                end
            end

            S_WAIT_DONE: begin
                wd_sel_done = 1'b1;
                if (mul_ready) begin
                    product_d = mul_product;
                    err_d     = 1'b0;
                    state_d   = S_HOLD;
                end else if (wd_hit) begin
                    product_d = (2*L_word)'(ERR_PRODUCT);
                    err_d     = 1'b1;
                    state_d   = S_HOLD;
                end else begin
                    wd_inc = 1'b1;
                end
            end

            S_HOLD: begin
                // A new pair is taken in the same cycle the result leaves.
                if (out_ready) begin
                    done_d    = done_q + 8'd1;
                    accept_en = 1'b1;
                    if (in_valid) begin
                        word1_d = in_word1;
                        word2_d = in_word2;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            word1_q   <= '0;
            word2_q   <= '0;
            product_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            word1_q   <= word1_d;
            word2_q   <= word2_d;
            product_q <= product_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign in_ready    = accept_en & ~reset;
    assign mul_start   = start_en & ~reset;
    assign out_valid   = (state_q == S_HOLD) & ~reset;
    assign mul_word1   = word1_q;
    assign mul_word2   = word2_q;
    assign out_product = product_q;
    assign out_err     = err_q;
    assign done_count  = done_q;

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Directed bench for booth_mult_sequencer with a behavioural Booth multiplier
// whose busy time is 5 cycles plus one per Booth add/subtract.
module tb_booth_mult_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_word1 = 4'd0;
    logic [3:0] in_word2 = 4'd0;
    logic [3:0] mul_word1;
    logic [3:0] mul_word2;
    logic       mul_start;
    logic       mul_ready;
    logic [7:0] mul_product;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_product;
    logic       out_err;
    logic [7:0] done_count;

    int total = 0;
    int bad   = 0;
    int mode  = 0;   // 0: multiplier, 1: Ready stuck high, 2: Ready low forever after Start
    int busy_cnt = 0;

    always #5 clock = ~clock;

    booth_mult_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word1    (in_word1),
        .in_word2    (in_word2),
        .mul_word1   (mul_word1),
        .mul_word2   (mul_word2),
        .mul_start   (mul_start),
        .mul_ready   (mul_ready),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_err     (out_err),
        .done_count  (done_count)
    );

    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
        return sa * sb;
    endfunction

    function automatic int booth_ops(input logic [3:0] q);
        int   n;
        logic prev;
        n = 0;
        prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (q[i] != prev) n++;
            prev = q[i];
        end
        return n;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            mul_ready   <= 1'b1;
            mul_product <= 8'hA5;
            busy_cnt    <= 0;
        end else if (mode == 0) begin
            if (mul_ready && mul_start) begin
                mul_ready   <= 1'b0;
                busy_cnt    <= 5 + booth_ops(mul_word2);
                mul_product <= ref_mul(mul_word1, mul_word2);
            end else if (!mul_ready) begin
                if (busy_cnt <= 1) mul_ready <= 1'b1;
                busy_cnt <= busy_cnt - 1;
            end
        end else if (mode == 2) begin
            if (mul_start) begin
                mul_ready   <= 1'b0;
                mul_product <= 8'h5A;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_accept(input logic [3:0] a, input logic [3:0] b, output bit ok);
        in_word1 = a;
        in_word2 = b;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts rising edges until out_valid is seen high.
    task automatic wait_valid(output int edges, output bit ok);
        ok = 1'b0;
        edges = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        total++;
        if (out_valid !== 1'b0 || out_err !== 1'b0 || out_product !== 8'h00) begin
            bad++; $display("FAIL reset_out: got v=%b e=%b p=%h want 0 0 00", out_valid, out_err, out_product);
        end
        total++;
        if (done_count !== 8'd0 || mul_start !== 1'b0) begin
            bad++; $display("FAIL reset_count_start: got dc=%0d st=%b want 0 0", done_count, mul_start);
        end
        total++;
        if (mul_word1 !== 4'd0 || mul_word2 !== 4'd0) begin
            bad++; $display("FAIL reset_words: got %h %h want 0 0", mul_word1, mul_word2);
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
        $display("test_reset checked");
    endtask

    task automatic test_basic();
        logic [3:0] ta[4];
        logic [3:0] tb[4];
        logic [7:0] te[4];
        int         tl[4];
        int         lat;
        bit         ok;
        ta = '{4'd3, 4'hD, 4'h8, 4'd3};
        tb = '{4'd5, 4'd5, 4'h8, 4'd0};
        te = '{8'h0F, 8'hF1, 8'h40, 8'h00};
        tl = '{11, 11, 8, 7};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            do_accept(ta[k], tb[k], ok);
            total++;
            if (!ok) begin bad++; $display("FAIL basic_accept_%0d: in_ready got 0 want 1", k); end
            wait_valid(lat, ok);
            total++;
            if (!ok || lat != tl[k]) begin
                bad++; $display("FAIL basic_latency_%0d: got %0d want %0d", k, lat, tl[k]);
            end
            total++;
            if (out_product !== te[k] || out_err !== 1'b0) begin
                bad++; $display("FAIL basic_product_%0d: got %h err=%b want %h err=0", k, out_product, out_err, te[k]);
            end
            @(posedge clock);
            @(negedge clock);
            total++;
            if (done_count !== 8'(k + 1) || out_valid !== 1'b0) begin
                bad++; $display("FAIL basic_done_%0d: got dc=%0d v=%b want %0d 0", k, done_count, out_valid, k + 1);
            end
            $display("basic %h x %h -> %h lat=%0d", ta[k], tb[k], out_product, lat);
        end
    endtask

    task automatic test_backpressure();
        int  lat;
        bit  ok;
        bit  held;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        do_accept(4'd2, 4'd3, ok);
        wait_valid(lat, ok);
        total++;
        if (!ok || out_product !== 8'h06) begin
            bad++; $display("FAIL bp_result: got ok=%b p=%h want 1 06", ok, out_product);
        end
        @(posedge clock);
        #1;
        in_word1 = 4'd1;
        in_word2 = 4'd1;
        in_valid = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b1 || out_product !== 8'h06 || in_ready !== 1'b0 || mul_start !== 1'b0) held = 1'b0;
        end
        total++;
        if (!held) begin
            bad++; $display("FAIL bp_hold: got v=%b p=%h ir=%b st=%b want 1 06 0 0", out_valid, out_product, in_ready, mul_start);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(negedge clock);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_passthru_ready: got %b want 1", in_ready); end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        total++;
        if (mul_start !== 1'b1 || out_valid !== 1'b0 || done_count !== 8'd5) begin
            bad++; $display("FAIL bp_restart: got st=%b v=%b dc=%0d want 1 0 5", mul_start, out_valid, done_count);
        end
        wait_valid(lat, ok);
        total++;
        if (!ok || out_product !== 8'h01 || out_err !== 1'b0) begin
            bad++; $display("FAIL bp_second: got ok=%b p=%h e=%b want 1 01 0", ok, out_product, out_err);
        end
        @(posedge clock);
        @(negedge clock);
        total++;
        if (done_count !== 8'd6) begin bad++; $display("FAIL bp_done: got %0d want 6", done_count); end
        $display("backpressure second result %h", out_product);
    endtask

    task automatic test_stuck_ready();
        bit ok;
        mode = 1;
        @(posedge clock);
        #1;
        do_accept(4'd6, 4'd7, ok);
        @(negedge clock);
        total++;
        if (mul_start !== 1'b1) begin bad++; $display("FAIL sr_start: got %b want 1", mul_start); end
        @(negedge clock);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL sr_early: got v=%b want 0", out_valid); end
        @(negedge clock);
        total++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_product !== 8'h00) begin
            bad++; $display("FAIL sr_timeout: got v=%b e=%b p=%h want 1 1 00", out_valid, out_err, out_product);
        end
        @(posedge clock);
        @(negedge clock);
        total++;
        if (done_count !== 8'd7) begin bad++; $display("FAIL sr_done: got %0d want 7", done_count); end
        mode = 0;
        $display("stuck_ready err=%b", out_err);
    endtask

    task automatic test_stuck_busy();
        bit ok;
        bit quiet;
        mode = 2;
        @(posedge clock);
        #1;
        do_accept(4'd6, 4'd7, ok);
        @(negedge clock);
        total++;
        if (mul_start !== 1'b1) begin bad++; $display("FAIL sb_start: got %b want 1", mul_start); end
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL sb_early: got out_valid=1 want 0 before cycle 21"); end
        @(negedge clock);
        total++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_product !== 8'h00) begin
            bad++; $display("FAIL sb_timeout: got v=%b e=%b p=%h want 1 1 00", out_valid, out_err, out_product);
        end
        @(posedge clock);
        @(negedge clock);
        total++;
        if (done_count !== 8'd8) begin bad++; $display("FAIL sb_done: got %0d want 8", done_count); end
        mode = 0;
        $display("stuck_busy err=%b", out_err);
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok;
        bit quiet;
        @(posedge clock);
        #1;
        apply_reset();
        do_accept(4'd5, 4'd5, ok);
        repeat (3) @(negedge clock);
        total++;
        if (mul_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL rm_busy: got rdy=%b v=%b want 0 0", mul_ready, out_valid);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || done_count !== 8'd0) begin
            bad++; $display("FAIL rm_after: got v=%b ir=%b dc=%0d want 0 1 0", out_valid, in_ready, done_count);
        end
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL rm_dropped: got out_valid=1 want 0"); end
        @(posedge clock);
        #1;
        do_accept(4'd7, 4'd2, ok);
        wait_valid(lat, ok);
        total++;
        if (!ok || out_product !== 8'h0E || out_err !== 1'b0) begin
            bad++; $display("FAIL rm_next: got ok=%b p=%h e=%b want 1 0E 0", ok, out_product, out_err);
        end
        @(posedge clock);
        @(negedge clock);
        $display("reset_mid next product 0E checked");
    endtask

    task automatic test_back_to_back();
        int         n_in;
        int         n_out;
        int         cyc;
        bit         acc;
        logic [7:0] kk;
        logic [7:0] expv;
        @(posedge clock);
        #1;
        apply_reset();
        out_ready = 1'b1;
        n_in = 0;
        n_out = 0;
        cyc = 0;
        in_word1 = 4'd0;
        in_word2 = 4'd0;
        in_valid = 1'b1;
        while ((n_out < 256) && (cyc < 8000)) begin
            @(negedge clock);
            acc = in_valid && (in_ready === 1'b1);
            if (out_valid === 1'b1) begin
                kk = 8'(n_out);
                expv = ref_mul(kk[7:4], kk[3:0]);
                total++;
                if (out_product !== expv || out_err !== 1'b0) begin
                    bad++; $display("FAIL b2b_%0d: got %h e=%b want %h", n_out, out_product, out_err, expv);
                end
                if (n_out == 128) begin
                    total++;
                    if (done_count !== 8'd128) begin bad++; $display("FAIL b2b_mid_count: got %0d want 128", done_count); end
                end
                n_out++;
            end
            @(posedge clock);
            #1;
            if (acc) begin
                n_in++;
                if (n_in < 256) begin
                    kk = 8'(n_in);
                    in_word1 = kk[7:4];
                    in_word2 = kk[3:0];
                end else begin
                    in_valid = 1'b0;
                end
            end
            cyc++;
        end
        total++;
        if (n_out != 256) begin bad++; $display("FAIL b2b_timeout: got %0d results want 256", n_out); end
        @(negedge clock);
        total++;
        if (done_count !== 8'd0) begin bad++; $display("FAIL b2b_wrap: got %0d want 0", done_count); end
        $display("back_to_back results=%0d cycles=%0d", n_out, cyc);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stuck_ready();
        test_stuck_busy();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at 400000");
        $fatal(1);
    end

endmodule
